// File: rtl/vector_stream_sequencer_pkg.sv
// Shared types and defaults for the vector stream sequencer and its read pipe.
package vector_stream_sequencer_pkg;

    typedef logic [7:0] data_t;
    typedef logic [3:0] nibble_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_RDY,
        DRAIN,
        DONE
    } seq_state_t;

    localparam int RD_LAT_DEFAULT     = 1;
    localparam int MAX_PASSES_DEFAULT = 8;

endpackage

// File: rtl/vector_stream_sequencer_seq_read_pipe.sv
// Tracks the single FIFO pop in flight and holds the popped element
// in the sink output register until the consumer takes it.
module seq_read_pipe
    import vector_stream_sequencer_pkg::*;
#(
    parameter int RD_LAT = RD_LAT_DEFAULT
)(
    input  logic  clk,
    input  logic  rst,
    input  logic  pop,
    input  logic  flush,
    input  data_t rdata,
    input  logic  sink_ready,
    output logic  capture,
    output logic  in_flight,
    output logic  sink_valid,
    output data_t sink_data
);

    logic [RD_LAT-1:0] pop_sr;
    logic [RD_LAT-1:0] pop_sr_next;

    generate
        if (RD_LAT == 1) begin : g_lat1
            assign pop_sr_next = pop;
        end else begin : g_latn
            assign pop_sr_next = {pop_sr[RD_LAT-2:0], pop};
        end
    endgenerate

    // fifo_rdata is valid exactly when the pop reaches the last stage
    assign capture   = pop_sr[RD_LAT-1];
    assign in_flight = |pop_sr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pop_sr     <= '0;
            sink_valid <= 1'b0;
            sink_data  <= '0;
        end else if (flush) begin
            pop_sr     <= '0;
            sink_valid <= 1'b0;
            sink_data  <= '0;
        end else begin
            pop_sr <= pop_sr_next;
            if (capture) begin
                sink_valid <= 1'b1;
                sink_data  <= rdata;
            end else if (sink_ready) begin
                sink_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/vector_stream_sequencer.sv
// Loads an N-element vector into fifo_vector, then drains it to the sink
// PASSES times, re-pushing each element on all but the final pass.
//
// state    | meaning
// IDLE     | waiting for a valid start; bad config sets err
// LOAD     | accepting N source elements into the FIFO
// WAIT_RDY | waiting for the FIFO ready flag
// DRAIN    | popping elements to the sink, replaying when passes remain
// DONE     | one-cycle done pulse, then IDLE
module vector_stream_sequencer
    import vector_stream_sequencer_pkg::*;
#(
    parameter  int RD_LAT     = RD_LAT_DEFAULT,
    parameter  int MAX_PASSES = MAX_PASSES_DEFAULT,
    localparam int PW         = $clog2(MAX_PASSES + 1)
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  nibble_t       N,
    input  logic [PW-1:0] passes,
    input  logic          src_valid,
    input  data_t         src_data,
    output logic          src_ready,
    output logic          fifo_push,
    output logic          fifo_pop,
    output data_t         fifo_wdata,
    input  data_t         fifo_rdata,
    input  logic          fifo_ready,
    output logic          sink_valid,
    output data_t         sink_data,
    input  logic          sink_ready,
    output logic          sink_last,
    output logic          busy,
    output logic          done,
    output logic          err
);

    seq_state_t    state;
    nibble_t       n_q;
    logic [PW-1:0] passes_q;
    logic [PW-1:0] pass_cnt;
    nibble_t       load_cnt;
    nibble_t       elem_cnt;
    nibble_t       issue_cnt;

    logic capture;
    logic in_flight;
    logic abort;
    logic pop_ok;
    logic last_accept;
    logic final_pass;

    assign abort       = (state == DRAIN) && !fifo_ready;
    // one pop at a time, issued only when the output register can take it
    assign pop_ok      = !fifo_pop && !in_flight && (issue_cnt != n_q) &&
                         (!sink_valid || sink_ready);
    assign last_accept = sink_valid && sink_ready && sink_last;
    assign final_pass  = (pass_cnt + PW'(1)) == passes_q;

    seq_read_pipe #(.RD_LAT(RD_LAT)) u_read_pipe (
        .clk        (clk),
        .rst        (rst),
        .pop        (fifo_pop),
        .flush      (abort),
        .rdata      (fifo_rdata),
        .sink_ready (sink_ready),
        .capture    (capture),
        .in_flight  (in_flight),
        .sink_valid (sink_valid),
        .sink_data  (sink_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            n_q        <= '0;
            passes_q   <= '0;
            pass_cnt   <= '0;
            load_cnt   <= '0;
            elem_cnt   <= '0;
            issue_cnt  <= '0;
            src_ready  <= 1'b0;
            fifo_push  <= 1'b0;
            fifo_pop   <= 1'b0;
            fifo_wdata <= '0;
            sink_last  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            fifo_push <= 1'b0;
            fifo_pop  <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (N == '0 || passes == '0 || passes > PW'(MAX_PASSES)) begin
                            err <= 1'b1;
                        end else begin
                            n_q       <= N;
                            passes_q  <= passes;
                            load_cnt  <= '0;
                            err       <= 1'b0;
                            busy      <= 1'b1;
                            src_ready <= 1'b1;
                            state     <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (src_valid) begin
                        fifo_push  <= 1'b1;
                        fifo_wdata <= src_data;
                        load_cnt   <= load_cnt + 4'd1;
                        if (load_cnt == n_q - 4'd1) begin
                            src_ready <= 1'b0;
                            state     <= WAIT_RDY;
                        end
                    end
                end
                WAIT_RDY: begin
                    if (fifo_ready) begin
                        pass_cnt  <= '0;
                        elem_cnt  <= '0;
                        issue_cnt <= '0;
                        sink_last <= 1'b0;
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!fifo_ready) begin
                        err       <= 1'b1;
                        busy      <= 1'b0;
                        sink_last <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        if (pop_ok) begin
                            fifo_pop  <= 1'b1;
                            issue_cnt <= issue_cnt + 4'd1;
                        end
                        if (capture) begin
                            elem_cnt  <= elem_cnt + 4'd1;
                            sink_last <= (elem_cnt == n_q - 4'd1);
                            if (!final_pass) begin
                                fifo_push  <= 1'b1;
                                fifo_wdata <= fifo_rdata;
                            end
                        end else if (sink_valid && sink_ready) begin
                            sink_last <= 1'b0;
                        end
                        if (last_accept) begin
                            elem_cnt  <= '0;
                            issue_cnt <= '0;
                            if (final_pass) begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= DONE;
                            end else begin
                                pass_cnt <= pass_cnt + PW'(1);
                            end
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vector_stream_sequencer.sv
// Directed and randomized jobs for the sequencer, with a queue-based FIFO
// stand-in and an expected sink stream computed from N, passes and the vector.
module tb_vector_stream_sequencer;
    import vector_stream_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    nibble_t    N = '0;
    logic [3:0] passes = '0;
    logic       src_valid = 1'b0;
    data_t      src_data = '0;
    logic       src_ready;
    logic       fifo_push;
    logic       fifo_pop;
    data_t      fifo_wdata;
    data_t      fifo_rdata;
    logic       fifo_ready;
    logic       sink_valid;
    data_t      sink_data;
    logic       sink_ready = 1'b1;
    logic       sink_last;
    logic       busy;
    logic       done;
    logic       err;

    int checks = 0;
    int errors = 0;

    vector_stream_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .N(N), .passes(passes),
        .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
        .fifo_push(fifo_push), .fifo_pop(fifo_pop), .fifo_wdata(fifo_wdata),
        .fifo_rdata(fifo_rdata), .fifo_ready(fifo_ready),
        .sink_valid(sink_valid), .sink_data(sink_data), .sink_ready(sink_ready),
        .sink_last(sink_last), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // FIFO stand-in: ready latches once the loaded vector is fully present
    data_t fq[$];
    logic  rdy_flag;
    logic  drop = 1'b0;
    int    cur_n;
    assign fifo_ready = rdy_flag && !drop;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            fq.delete();
            rdy_flag   <= 1'b0;
            fifo_rdata <= '0;
            cur_n      <= 0;
        end else if (start && !busy) begin
            fq.delete();
            rdy_flag <= 1'b0;
            cur_n    <= int'(N);
        end else begin
            if (fifo_pop && fq.size() > 0) fifo_rdata <= fq.pop_front();
            if (fifo_push) fq.push_back(fifo_wdata);
            if (cur_n != 0 && fq.size() >= cur_n) rdy_flag <= 1'b1;
        end
    end

    int         push_cnt = 0;
    int         pop_cnt = 0;
    int         acc_cnt = 0;
    int         done_cnt = 0;
    logic [8:0] got_log [0:4095];

    always @(posedge clk) begin
        if (rst) begin
            if (fifo_push) push_cnt <= push_cnt + 1;
            if (fifo_pop) pop_cnt <= pop_cnt + 1;
            if (done) done_cnt <= done_cnt + 1;
            if (sink_valid && sink_ready) begin
                got_log[acc_cnt % 4096] <= {sink_last, sink_data};
                acc_cnt <= acc_cnt + 1;
            end
        end
    end

    data_t vec [0:15];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // src_mode: 0 back-to-back, 1 alternating with junk after load, 2 random
    // sink_mode: 0 always ready, 1 random, 2 stall 5 cycles on first element
    // abort_mode: 0 none, 1 reset after 2 accepts, 2 fifo_ready drop after 1
    task automatic run_job(input int n, input int p, input int src_mode,
                           input int sink_mode, input int abort_mode);
        int         idx = 0;
        int         push_b, acc_b, pop_b, done_b;
        int         stall_left = 5;
        int         pop_snap = 0;
        bit         got_done = 0, rdy_pending = 0, alt = 1, stall_done = 0, v;
        logic [8:0] e;
        push_b = push_cnt; acc_b = acc_cnt; pop_b = pop_cnt; done_b = done_cnt;
        @(negedge clk);
        N = nibble_t'(n); passes = 4'(p); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_err_clear", err, 0);
        chk("start_busy", busy, 1);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc != 0) @(negedge clk);
            if (done) begin got_done = 1; break; end
            if (abort_mode == 1 && acc_cnt - acc_b >= 2) begin
                #2 rst = 1'b0;
                #1;
                chk("rst_outputs", {src_ready, fifo_push, fifo_pop, sink_valid, sink_last,
                                    busy, done, err, sink_data, fifo_wdata}, 0);
                src_valid = 1'b0; sink_ready = 1'b1;
                @(negedge clk);
                rst = 1'b1;
                return;
            end
            if (abort_mode == 2 && acc_cnt - acc_b >= 1) begin
                drop = 1'b1; src_valid = 1'b0; sink_ready = 1'b1;
                @(negedge clk);
                chk("drop_err", err, 1);
                chk("drop_busy", busy, 0);
                chk("drop_sink_valid", sink_valid, 0);
                repeat (6) @(negedge clk);
                chk("drop_no_done", done_cnt - done_b, 0);
                drop = 1'b0;
                return;
            end
            if (rdy_pending) begin
                chk("src_ready_drop", src_ready, 0);
                rdy_pending = 0;
            end
            case (src_mode)
                0: v = (idx < n);
                1: begin v = (idx < n) ? alt : 1'b1; alt = !alt; end
                default: v = (idx < n) && ($urandom_range(0, 2) != 0);
            endcase
            src_valid = v;
            src_data  = (idx < n) ? vec[idx] : 8'hEE;
            if (v && src_ready && idx < n) begin
                idx++;
                if (idx == n) rdy_pending = 1;
            end
            case (sink_mode)
                0: sink_ready = 1'b1;
                1: sink_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (sink_valid && stall_left > 0) begin
                        if (stall_left == 5) pop_snap = pop_cnt;
                        chk("stall_data", sink_data, vec[0]);
                        sink_ready = 1'b0;
                        stall_left--;
                    end else begin
                        if (stall_left == 0 && !stall_done) begin
                            chk("stall_hold_data", sink_data, vec[0]);
                            chk("stall_no_pop", pop_cnt - pop_snap, 0);
                            stall_done = 1;
                        end
                        sink_ready = 1'b1;
                    end
                end
            endcase
        end
        src_valid = 1'b0;
        sink_ready = 1'b1;
        chk("job_done_seen", got_done, 1);
        @(negedge clk);
        chk("post_busy", busy, 0);
        chk("post_done_low", done, 0);
        chk("done_pulses", done_cnt - done_b, 1);
        chk("acc_count", acc_cnt - acc_b, n * p);
        chk("push_count", push_cnt - push_b, n * p);
        chk("pop_count", pop_cnt - pop_b, n * p);
        for (int k = 0; k < n * p && k < acc_cnt - acc_b; k++) begin
            e[8]   = ((k % n) == n - 1);
            e[7:0] = vec[k % n];
            chk("sink_elem", got_log[(acc_b + k) % 4096], e);
        end
    endtask

    task automatic bad_start(input int n, input int p);
        int push_b;
        push_b = push_cnt;
        @(negedge clk);
        N = nibble_t'(n); passes = 4'(p); start = 1'b1;
        src_valid = 1'b1; src_data = 8'h5A;
        @(negedge clk);
        start = 1'b0;
        chk("bad_err", err, 1);
        chk("bad_busy", busy, 0);
        repeat (3) @(negedge clk);
        chk("bad_src_ready", src_ready, 0);
        chk("bad_no_push", push_cnt - push_b, 0);
        src_valid = 1'b0;
    endtask

    task automatic rand_vec();
        for (int i = 0; i < 16; i++) vec[i] = data_t'($urandom);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) vec[i] = '0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {src_ready, fifo_push, fifo_pop, sink_valid, sink_last,
                              busy, done, err, sink_data, fifo_wdata}, 0);
        rst = 1'b1;
        @(negedge clk);

        vec[0] = 8'h11; vec[1] = 8'h22; vec[2] = 8'h33; vec[3] = 8'h44;
        run_job(4, 1, 0, 0, 0);

        vec[0] = 8'h05; vec[1] = 8'h06; vec[2] = 8'h07;
        run_job(3, 3, 0, 0, 0);

        vec[0] = 8'h0A; vec[1] = 8'h0B;
        run_job(2, 1, 0, 2, 0);

        vec[0] = 8'hC1; vec[1] = 8'hC2;
        run_job(2, 1, 1, 0, 0);

        bad_start(0, 1);
        rand_vec();
        run_job(3, 2, 2, 1, 0);
        bad_start(3, 9);
        rand_vec();
        run_job(5, 1, 2, 1, 0);
        bad_start(3, 0);

        rand_vec();
        run_job(4, 1, 0, 0, 1);
        vec[0] = 8'h99;
        run_job(1, 1, 0, 0, 0);

        rand_vec();
        run_job(4, 2, 0, 0, 2);

        rand_vec();
        run_job(15, 8, 2, 1, 0);
        repeat (8) begin
            rand_vec();
            run_job($urandom_range(1, 15), $urandom_range(1, 8), 2, 1, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
